// File: rtl/spi_target_bridge.sv
// SPI target that turns controller frames (command byte, then data/dummy bytes)
// into single-cycle accesses on a byte-wide register bus. SPI pins are oversampled in clk.
module spi_target_bridge #(
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs_i,
  input  logic                  sclk_i,
  input  logic                  sdi,
  output logic                  sdo,
  output logic                  sdo_oe,
  output logic                  bus_enable,
  output logic                  bus_write_enable,
  output logic [ADDR_WIDTH-1:0] bus_address,
  output logic [7:0]            bus_write_data,
  input  logic [7:0]            bus_read_data,
  output logic                  frame_done
);
  typedef enum logic [2:0] {IDLE, CMD, RD_REQ, RD_CAP, DATA, WR_REQ} state_e;
  localparam bit SAMPLE_ON_FALL = CPOL ^ CPHA;

  state_e                state_q, state_d;
  logic [1:0]            cs_sync_q, sclk_sync_q, sdi_sync_q;
  logic                  cs_prev_q, sclk_prev_q;
  logic [6:0]            rx_shift_q, rx_shift_d;
  logic [7:0]            tx_shift_q, tx_shift_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  rw_q, rw_d;
  logic                  frame_done_q;

  logic       cs_s, sclk_s, sdi_s;
  logic       cs_fall, cs_rise, sclk_rise, sclk_fall, active;
  logic       sample_edge, shift_edge, byte_done;
  logic [7:0] rx_byte;

  assign cs_s        = cs_sync_q[1];
  assign sclk_s      = sclk_sync_q[1];
  assign sdi_s       = sdi_sync_q[1];
  assign cs_fall     = cs_prev_q & ~cs_s;
  assign cs_rise     = ~cs_prev_q & cs_s;
  assign sclk_rise   = sclk_s & ~sclk_prev_q;
  assign sclk_fall   = ~sclk_s & sclk_prev_q;
  assign active      = (state_q != IDLE) && !cs_s;
  assign sample_edge = active && (SAMPLE_ON_FALL ? sclk_fall : sclk_rise);
  assign shift_edge  = active && (SAMPLE_ON_FALL ? sclk_rise : sclk_fall);
  assign rx_byte     = {rx_shift_q, sdi_s};
  assign byte_done   = sample_edge && (bit_cnt_q == 3'd7);

  always_comb begin
    state_d    = state_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    bit_cnt_d  = bit_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rw_d       = rw_q;
    if (sample_edge) begin
      rx_shift_d = rx_byte[6:0];
      bit_cnt_d  = bit_cnt_q + 3'd1;
    end
    // Bit 7 of each byte is already on sdo once loaded, so the shift edge at a
    // byte boundary must not consume it (holds for both CPHA settings).
    if (shift_edge && (bit_cnt_q != 3'd0)) tx_shift_d = {tx_shift_q[6:0], 1'b0};
    case (state_q)
      IDLE: if (cs_fall) begin
        state_d    = CMD;
        bit_cnt_d  = 3'd0;
        rx_shift_d = '0;
        tx_shift_d = '0;
      end
      CMD: if (byte_done) begin
        addr_d  = rx_byte[ADDR_WIDTH-1:0];
        rw_d    = rx_byte[7];
        state_d = rx_byte[7] ? RD_REQ : DATA;
      end
      RD_REQ: state_d = RD_CAP;
      RD_CAP: begin
        tx_shift_d = bus_read_data;
        state_d    = DATA;
      end
      DATA: if (byte_done) begin
        if (rw_q) begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = RD_REQ;
        end else begin
          wdata_d = rx_byte;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        addr_d  = addr_q + ADDR_WIDTH'(1);
        state_d = DATA;
      end
      default: state_d = IDLE;
    endcase
    if (cs_rise) begin
      state_d    = IDLE;
      tx_shift_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync_q    <= 2'b11;
      sclk_sync_q  <= {2{CPOL}};
      sdi_sync_q   <= 2'b00;
      cs_prev_q    <= 1'b1;
      sclk_prev_q  <= CPOL;
      state_q      <= IDLE;
      rx_shift_q   <= '0;
      tx_shift_q   <= '0;
      bit_cnt_q    <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rw_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cs_sync_q    <= {cs_sync_q[0], cs_i};
      sclk_sync_q  <= {sclk_sync_q[0], sclk_i};
      sdi_sync_q   <= {sdi_sync_q[0], sdi};
      cs_prev_q    <= cs_s;
      sclk_prev_q  <= sclk_s;
      state_q      <= state_d;
      rx_shift_q   <= rx_shift_d;
      tx_shift_q   <= tx_shift_d;
      bit_cnt_q    <= bit_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rw_q         <= rw_d;
      frame_done_q <= cs_rise;
    end
  end

  assign sdo              = tx_shift_q[7];
  assign sdo_oe           = (state_q != IDLE);
  assign bus_enable       = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign bus_write_enable = (state_q == WR_REQ);
  assign bus_address      = addr_q;
  assign bus_write_data   = wdata_q;
  assign frame_done       = frame_done_q;

endmodule
